generation_buffer: RTL and testbench

//  Responder for the controller's strobe protocol (write_array, write_mem, pos, run).

---
 rtl/generation_buffer.sv | 124 ++++++++++++
 tb/tb_generation_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/generation_buffer.sv
// Double-buffered cell ring for the controller's strobe protocol.
// Stages one cell per pos, commits it, then swaps in the new generation.
module generation_buffer #(
    parameter int                 N_CELLS = 4,
    parameter int                 POS_W   = 2,
    parameter logic [N_CELLS-1:0] SEED    = 4'b0110
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write_array,
    input  logic               write_mem,
    input  logic [POS_W-1:0]   pos,
    input  logic               run,
    input  logic               load_data,
    output logic [N_CELLS-1:0] cells,
    output logic               gen_done,
    output logic [7:0]         gen_count,
    output logic               protocol_err
);

    localparam logic [1:0] S_WAIT_ARRAY = 2'd0;
    localparam logic [1:0] S_WAIT_MEM   = 2'd1;
    localparam logic [1:0] S_SWAP       = 2'd2;

    localparam logic [POS_W-1:0] ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] LAST = POS_W'(N_CELLS - 1);

    logic [1:0]         r_state;
    logic [N_CELLS-1:0] r_cells;
    logic [N_CELLS-1:0] r_next;
    logic [N_CELLS-1:0] r_mask;
    logic               r_staged;
    logic [POS_W-1:0]   r_arm_pos;
    logic               r_arm_run;
    logic               r_gen_done;
    logic [7:0]         r_gen_count;
    logic               r_err;

    logic [POS_W-1:0]   w_prev;
    logic [POS_W-1:0]   w_succ;
    logic               w_stage_bit;
    logic               w_both;

    // Stage value: XOR of wrapped neighbours from the current buffer, or load data.
    always_comb begin
        w_prev      = pos - ONE;
        w_succ      = pos + ONE;
        w_stage_bit = run ? (r_cells[w_prev] ^ r_cells[w_succ]) : load_data;
        w_both      = write_array & write_mem;
    end

    // Protocol FSM, staging, commit and buffer swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT_ARRAY;
            r_cells     <= SEED;
            r_next      <= '0;
            r_mask      <= '0;
            r_staged    <= 1'b0;
            r_arm_pos   <= '0;
            r_arm_run   <= 1'b0;
            r_gen_done  <= 1'b0;
            r_gen_count <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_gen_done <= 1'b0;
            if (w_both && r_state != S_SWAP) begin
                r_err <= 1'b1;
            end else begin
                case (r_state)
                    S_WAIT_ARRAY: begin
                        if (write_array) begin
                            r_arm_pos <= pos;
                            r_arm_run <= run;
                            r_staged  <= w_stage_bit;
                            r_state   <= S_WAIT_MEM;
                        end else if (write_mem) begin
                            r_err <= 1'b1;
                        end
                    end
                    S_WAIT_MEM: begin
                        if (write_array) begin
                            r_arm_pos <= pos;
                            r_arm_run <= run;
                            r_staged  <= w_stage_bit;
                        end else if (write_mem) begin
                            if (pos == r_arm_pos) begin
                                r_next[pos] <= r_staged;
                                r_mask[pos] <= 1'b1;
                                r_state     <= (pos == LAST) ? S_SWAP
                                                             : S_WAIT_ARRAY;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_WAIT_ARRAY;
                            end
                        end
                    end
                    S_SWAP: begin
                        if (&r_mask) begin
                            r_cells    <= r_next;
                            r_gen_done <= 1'b1;
                            if (r_arm_run) begin
                                r_gen_count <= r_gen_count + 8'd1;
                            end else begin
                                r_gen_count <= 8'd0;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_mask  <= '0;
                        r_state <= S_WAIT_ARRAY;
                    end
                    default: r_state <= S_WAIT_ARRAY;
                endcase
            end
        end
    end

    assign cells        = r_cells;
    assign gen_done     = r_gen_done;
    assign gen_count    = r_gen_count;
    assign protocol_err = r_err;

endmodule

// File: tb/tb_generation_buffer.sv
// Directed bench for generation_buffer.
// Expected values are hand-derived from the XOR-neighbour rule.
module tb_generation_buffer;

    logic       clk;
    logic       reset;
    logic       write_array;
    logic       write_mem;
    logic [1:0] pos;
    logic       run;
    logic       load_data;
    logic [3:0] cells;
    logic       gen_done;
    logic [7:0] gen_count;
    logic       protocol_err;

    int n_tests;
    int n_fail;
    int pulses;

    generation_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .write_array  (write_array),
        .write_mem    (write_mem),
        .pos          (pos),
        .run          (run),
        .load_data    (load_data),
        .cells        (cells),
        .gen_done     (gen_done),
        .gen_count    (gen_count),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic wa, input logic wm, input logic [1:0] p,
                        input logic r, input logic d);
        write_array = wa;
        write_mem   = wm;
        pos         = p;
        run         = r;
        load_data   = d;
        tick();
        write_array = 1'b0;
        write_mem   = 1'b0;
    endtask

    // Full array/idle/mem sequence for pos0..3, then watch for gen_done.
    task automatic gen_seq(input string tag, input logic r,
                           input logic [3:0] data);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i), r, data[i]);
            step(1'b0, 1'b0, 2'(i), r, data[i]);
            step(1'b0, 1'b1, 2'(i), r, data[i]);
        end
        chk({tag, "_done_early"}, 32'(gen_done), 32'd0);
        tick();
        chk({tag, "_done_lat"}, 32'(gen_done), 32'd1);
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (gen_done) pulses++;
        end
        chk({tag, "_extra_pulse"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        write_array = 1'b0;
        write_mem   = 1'b0;
        pos         = 2'd0;
        run         = 1'b0;
        load_data   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_cells", 32'(cells), 32'h6);
        chk("rst_done", 32'(gen_done), 32'd0);
        chk("rst_count", 32'(gen_count), 32'd0);
        chk("rst_err", 32'(protocol_err), 32'd0);

        gen_seq("g1", 1'b1, 4'b0000);
        chk("g1_cells", 32'(cells), 32'hF);
        chk("g1_count", 32'(gen_count), 32'd1);
        chk("g1_err", 32'(protocol_err), 32'd0);

        gen_seq("g2", 1'b1, 4'b0000);
        chk("g2_cells", 32'(cells), 32'h0);
        chk("g2_count", 32'(gen_count), 32'd2);

        gen_seq("g3", 1'b1, 4'b0000);
        chk("g3_cells", 32'(cells), 32'h0);
        chk("g3_count", 32'(gen_count), 32'd3);

        gen_seq("ld", 1'b0, 4'b1001);
        chk("ld_cells", 32'(cells), 32'h9);
        chk("ld_count", 32'(gen_count), 32'd0);

        gen_seq("ev", 1'b1, 4'b0000);
        chk("ev_cells", 32'(cells), 32'hF);
        chk("ev_count", 32'(gen_count), 32'd1);

        step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        chk("pos_err", 32'(protocol_err), 32'd1);
        step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (gen_done) pulses++;
        end
        chk("inc_pulse", 32'(pulses), 32'd0);
        chk("inc_cells", 32'(cells), 32'hF);
        chk("inc_count", 32'(gen_count), 32'd1);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i), 1'b1, 1'b1);
            step(1'b0, 1'b1, 2'(i), 1'b0, 1'b1);
        end
        tick();
        tick();
        chk("mode_cells", 32'(cells), 32'h0);
        chk("mode_count", 32'(gen_count), 32'd2);
        chk("err_sticky", 32'(protocol_err), 32'd1);

        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_cells", 32'(cells), 32'h6);
        chk("mid_done", 32'(gen_done), 32'd0);
        chk("mid_count", 32'(gen_count), 32'd0);
        chk("mid_err", 32'(protocol_err), 32'd0);
        gen_seq("mr", 1'b1, 4'b0000);
        chk("mr_cells", 32'(cells), 32'hF);
        chk("mr_count", 32'(gen_count), 32'd1);

        step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        chk("both_err", 32'(protocol_err), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i), 1'b1, 1'b0);
            step(1'b0, 1'b1, 2'(i), 1'b1, 1'b0);
        end
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (gen_done) pulses++;
        end
        chk("both_pulse", 32'(pulses), 32'd0);
        chk("both_cells", 32'(cells), 32'hF);
        chk("both_count", 32'(gen_count), 32'd1);

        gen_seq("after", 1'b1, 4'b0000);
        chk("after_cells", 32'(cells), 32'h0);
        chk("after_count", 32'(gen_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
